// File: rtl/ekf_stage_scheduler.sv
// ekf_stage_scheduler
//   Queued stage sequencer in front of the EKF-SLAM core. Host requests
//   {stage, landmark} are screened and queued in a small FIFO. They are then
//   dispatched one at a time: a stage_val strobe is held for VAL_CYC cycles,
//   then the core's stage_rdy completion code is awaited, with a hang timeout.
//
// Ports
//   clk          : clock, rising edge
//   sys_rst      : synchronous reset, active low
//   req_val      : host request valid
//   req_stage    : requested stage (1 PRD, 2 NEW, 3 UPD, 4 ASSOC)
//   req_lk       : landmark index of the request
//   req_rdy      : queue can accept (combinational)
//   landmark_num : current landmark count, upper bound for NEW/UPD indices
//   stage_val    : stage strobe to the core
//   l_k          : landmark index to the core, held for the dispatch
//   stage_rdy    : completion code from the core (0 when nothing finished)
//   busy         : sequencer not idle
//   cur_stage    : stage in progress, 0 when idle
//   done_pulse   : one-cycle completion strobe
//   done_stage   : stage of the last completion
//   err_val      : one-cycle error strobe
//   err_code     : 0 illegal stage, 1 range, 2 order, 3 timeout
//   err_flag     : sticky error indicator
module ekf_stage_scheduler #(
  parameter int QUEUE_DEPTH = 4,
  parameter int ROW_LEN     = 10,
  parameter int VAL_CYC     = 2,
  parameter int TIMEOUT_W   = 12,
  parameter int TIMEOUT     = 4095
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               req_val,
  input  logic [2:0]         req_stage,
  input  logic [ROW_LEN-1:0] req_lk,
  output logic               req_rdy,
  input  logic [ROW_LEN-1:0] landmark_num,
  output logic [2:0]         stage_val,
  output logic [ROW_LEN-1:0] l_k,
  input  logic [2:0]         stage_rdy,
  output logic               busy,
  output logic [2:0]         cur_stage,
  output logic               done_pulse,
  output logic [2:0]         done_stage,
  output logic               err_val,
  output logic [1:0]         err_code,
  output logic               err_flag
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int VC_W  = (VAL_CYC > 1) ? $clog2(VAL_CYC) : 1;
  localparam int ENT_W = 3 + ROW_LEN;

  localparam logic [2:0] ST_PRD   = 3'd1;
  localparam logic [2:0] ST_NEW   = 3'd2;
  localparam logic [2:0] ST_UPD   = 3'd3;
  localparam logic [2:0] ST_ASSOC = 3'd4;

  localparam logic [1:0] ERR_ILLEGAL = 2'd0;
  localparam logic [1:0] ERR_RANGE   = 2'd1;
  localparam logic [1:0] ERR_ORDER   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // FIFO storage and control
  logic [ENT_W-1:0] mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // sequencer state
  logic [1:0]         state_q, state_d;
  logic [2:0]         cur_q, cur_d;
  logic [ROW_LEN-1:0] lk_q, lk_d;
  logic [2:0]         sval_q, sval_d;
  logic [VC_W-1:0]    vcnt_q, vcnt_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic               prd_done_q, prd_done_d;
  logic               done_p_q, done_p_d;
  logic [2:0]         done_s_q, done_s_d;
  logic               err_val_q, err_val_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               err_flag_q, err_flag_d;

  logic               full, empty, accept;
  logic               stage_legal, range_bad, enq_ill, enq_rng, push, pop;
  logic [2:0]         head_stage;
  logic [ROW_LEN-1:0] head_lk;
  logic               fsm_err;
  logic [1:0]         fsm_code;

  assign full    = (cnt_q == CNT_W'(QUEUE_DEPTH));
  assign empty   = (cnt_q == '0);
  // Full blocks acceptance even when a pop happens in the same cycle.
  assign req_rdy = sys_rst & ~full;
  assign accept  = req_val & req_rdy;

  assign stage_legal = (req_stage >= ST_PRD) && (req_stage <= ST_ASSOC);
  assign range_bad   = ((req_stage == ST_NEW) || (req_stage == ST_UPD)) &&
                       (req_lk >= landmark_num);
  assign enq_ill     = accept & ~stage_legal;
  assign enq_rng     = accept & stage_legal & range_bad;
  assign push        = accept & stage_legal & ~range_bad;

  assign head_stage  = mem_q[rd_ptr_q][ENT_W-1 -: 3];
  assign head_lk     = mem_q[rd_ptr_q][ROW_LEN-1:0];
  // An idle sequencer always consumes the head, whether it dispatches or drops it.
  assign pop         = (state_q == S_IDLE) && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    lk_d       = lk_q;
    sval_d     = sval_q;
    vcnt_d     = vcnt_q;
    tmo_d      = tmo_q;
    prd_done_d = prd_done_q;
    done_p_d   = 1'b0;
    done_s_d   = done_s_q;
    fsm_err    = 1'b0;
    fsm_code   = ERR_ORDER;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          if ((head_stage != ST_PRD) && !prd_done_q) begin
            // No prediction has completed yet: the entry is discarded.
            fsm_err  = 1'b1;
            fsm_code = ERR_ORDER;
          end else begin
            cur_d   = head_stage;
            lk_d    = head_lk;
            sval_d  = head_stage;
            vcnt_d  = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (vcnt_q == VC_W'(VAL_CYC - 1)) begin
          sval_d  = '0;
          tmo_d   = '0;
          state_d = S_WAIT;
        end else begin
          vcnt_d = vcnt_q + VC_W'(1);
        end
      end
      S_WAIT: begin
        if (stage_rdy == cur_q) begin
          done_p_d = 1'b1;
          done_s_d = cur_q;
          state_d  = S_DONE;
        end else if (tmo_q == TIMEOUT_W'(TIMEOUT - 1)) begin
          // This cycle is the TIMEOUT-th spent waiting.
          fsm_err  = 1'b1;
          fsm_code = ERR_TIMEOUT;
          cur_d    = '0;
          state_d  = S_IDLE;
        end else begin
          tmo_d = tmo_q + TIMEOUT_W'(1);
        end
      end
      S_DONE: begin
        if (cur_q == ST_PRD) begin
          prd_done_d = 1'b1;
        end
        cur_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer errors take priority over enqueue errors on err_code.
  always_comb begin
    err_val_d  = fsm_err | enq_ill | enq_rng;
    err_flag_d = err_flag_q | err_val_d;
    err_code_d = err_code_q;
    if (fsm_err) begin
      err_code_d = fsm_code;
    end else if (enq_ill) begin
      err_code_d = ERR_ILLEGAL;
    end else if (enq_rng) begin
      err_code_d = ERR_RANGE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_stage, req_lk};
    end
  end

  always_ff @(posedge clk) begin
    if (!sys_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      cur_q      <= '0;
      lk_q       <= '0;
      sval_q     <= '0;
      vcnt_q     <= '0;
      tmo_q      <= '0;
      prd_done_q <= 1'b0;
      done_p_q   <= 1'b0;
      done_s_q   <= '0;
      err_val_q  <= 1'b0;
      err_code_q <= '0;
      err_flag_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      cur_q      <= cur_d;
      lk_q       <= lk_d;
      sval_q     <= sval_d;
      vcnt_q     <= vcnt_d;
      tmo_q      <= tmo_d;
      prd_done_q <= prd_done_d;
      done_p_q   <= done_p_d;
      done_s_q   <= done_s_d;
      err_val_q  <= err_val_d;
      err_code_q <= err_code_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign stage_val  = sval_q;
  assign l_k        = lk_q;
  assign busy       = (state_q != S_IDLE);
  assign cur_stage  = cur_q;
  assign done_pulse = done_p_q;
  assign done_stage = done_s_q;
  assign err_val    = err_val_q;
  assign err_code   = err_code_q;
  assign err_flag   = err_flag_q;

endmodule

// File: tb/tb_ekf_stage_scheduler.sv
module tb_ekf_stage_scheduler;
  localparam int RL = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          sys_rst = 1'b0;
  logic          req_val = 1'b0;
  logic [2:0]    req_stage = '0;
  logic [RL-1:0] req_lk = '0;
  logic [RL-1:0] landmark_num = RL'(4);
  logic [2:0]    stage_rdy = '0;

  logic          req_rdy, busy, done_pulse, err_val, err_flag;
  logic [2:0]    stage_val, cur_stage, done_stage;
  logic [RL-1:0] l_k;
  logic [1:0]    err_code;

  logic          t_req_rdy, t_busy, t_done_pulse, t_err_val, t_err_flag;
  logic [2:0]    t_stage_val, t_cur_stage, t_done_stage;
  logic [RL-1:0] t_l_k;
  logic [1:0]    t_err_code;

  ekf_stage_scheduler #(.QUEUE_DEPTH(4), .ROW_LEN(RL), .VAL_CYC(2),
                        .TIMEOUT_W(12), .TIMEOUT(4095)) dut (
    .clk(clk), .sys_rst(sys_rst), .req_val(req_val), .req_stage(req_stage),
    .req_lk(req_lk), .req_rdy(req_rdy), .landmark_num(landmark_num),
    .stage_val(stage_val), .l_k(l_k), .stage_rdy(stage_rdy), .busy(busy),
    .cur_stage(cur_stage), .done_pulse(done_pulse), .done_stage(done_stage),
    .err_val(err_val), .err_code(err_code), .err_flag(err_flag));

  ekf_stage_scheduler #(.QUEUE_DEPTH(4), .ROW_LEN(RL), .VAL_CYC(2),
                        .TIMEOUT_W(12), .TIMEOUT(16)) dut_t (
    .clk(clk), .sys_rst(sys_rst), .req_val(req_val), .req_stage(req_stage),
    .req_lk(req_lk), .req_rdy(t_req_rdy), .landmark_num(landmark_num),
    .stage_val(t_stage_val), .l_k(t_l_k), .stage_rdy(stage_rdy), .busy(t_busy),
    .cur_stage(t_cur_stage), .done_pulse(t_done_pulse), .done_stage(t_done_stage),
    .err_val(t_err_val), .err_code(t_err_code), .err_flag(t_err_flag));

  typedef struct { logic [2:0] s; logic [RL-1:0] lk; } ent_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst   = 1'b0;
    req_val   = 1'b0;
    stage_rdy = '0;
    step();
    sys_rst   = 1'b1;
  endtask

  // Presents one request for one edge; returns at the sample after that edge.
  task automatic send(input logic [2:0] s, input logic [RL-1:0] lk);
    req_val   = 1'b1;
    req_stage = s;
    req_lk    = lk;
    step();
    req_val   = 1'b0;
  endtask

  // Acts as the core for one dispatch: waits for it, checks it, completes it.
  task automatic serve(input logic [2:0] s, input logic [RL-1:0] lk, input int dly);
    int n;
    n = 0;
    while (cur_stage == 3'd0 && n < 60) begin step(); n++; end
    check_eq("serve_stage", cur_stage, s);
    check_eq("serve_lk", l_k, lk);
    n = 0;
    while (stage_val != 3'd0 && n < 20) begin step(); n++; end
    repeat (dly) step();
    stage_rdy = s;
    step();
    stage_rdy = '0;
    check_eq("serve_done_pulse", done_pulse, 1);
    check_eq("serve_done_stage", done_stage, s);
    check_eq("serve_done_lk", l_k, lk);
    step();
    check_eq("serve_cur_cleared", cur_stage, 0);
  endtask

  task automatic random_phase();
    ent_t mq[$];
    ent_t e;
    int cph, cdly, icnt, left_prd;
    logic [2:0] cstg;
    logic [RL-1:0] clk_lk;
    logic acc, mprd, mflag;
    logic [2:0] a_stage;
    logic [RL-1:0] a_lk;
    cph = 0; cdly = 0; icnt = 0; cstg = '0; clk_lk = '0;
    mprd = 1'b0; mflag = 1'b0;
    do_reset();
    landmark_num = RL'(5);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc < 3400 && $urandom_range(0, 2) == 0) begin
        req_val   = 1'b1;
        req_stage = 3'($urandom_range(0, 7));
        req_lk    = RL'($urandom_range(0, 7));
      end else begin
        req_val = 1'b0;
      end
      #1;
      acc     = req_val & req_rdy;
      a_stage = req_stage;
      a_lk    = req_lk;
      step();
      req_val = 1'b0;
      if (acc) begin
        if (a_stage < 3'd1 || a_stage > 3'd4) begin
          check_eq("rnd_illegal_err", err_val, 1);
          mflag = 1'b1;
        end else if ((a_stage == 3'd2 || a_stage == 3'd3) && a_lk >= landmark_num) begin
          check_eq("rnd_range_err", err_val, 1);
          mflag = 1'b1;
        end else begin
          e.s = a_stage; e.lk = a_lk;
          mq.push_back(e);
        end
      end
      case (cph)
        0: if (stage_val != 3'd0) begin
          // Entries other than PRD are discarded until a PRD has completed.
          while (mq.size() > 0 && mq[0].s != 3'd1 && !mprd) begin
            void'(mq.pop_front());
            mflag = 1'b1;
          end
          if (mq.size() == 0) begin
            check_eq("rnd_unexpected_dispatch", stage_val, 0);
            cstg = stage_val; clk_lk = l_k;
          end else begin
            e = mq.pop_front();
            check_eq("rnd_disp_stage", stage_val, e.s);
            check_eq("rnd_disp_lk", l_k, e.lk);
            cstg = e.s; clk_lk = e.lk;
          end
          icnt = 1;
          cph  = 1;
        end
        1: if (stage_val != 3'd0) icnt++;
           else begin
             check_eq("rnd_val_len", icnt, 2);
             cdly = $urandom_range(0, 5);
             cph  = 2;
           end
        2: if (cdly == 0) begin
             stage_rdy = cstg;
             cph = 3;
           end else begin
             cdly--;
             stage_rdy = ($urandom_range(0, 1) == 1) ? 3'((cstg % 3'd4) + 3'd1) : 3'd0;
           end
        default: begin
          stage_rdy = '0;
          check_eq("rnd_done_pulse", done_pulse, 1);
          check_eq("rnd_done_stage", done_stage, cstg);
          check_eq("rnd_done_lk", l_k, clk_lk);
          if (cstg == 3'd1) mprd = 1'b1;
          cph = 0;
        end
      endcase
    end
    check_eq("rnd_end_busy", busy, 0);
    left_prd = 0;
    foreach (mq[i]) if (mq[i].s == 3'd1) left_prd++;
    if (!mprd && mq.size() > 0) mflag = 1'b1;
    check_eq("rnd_leftover", mprd ? mq.size() : left_prd, 0);
    check_eq("rnd_err_flag", err_flag, mflag);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0]    qs [6];
    logic [RL-1:0] ql [6];
    int n, seen_done;

    // reset state
    sys_rst = 1'b0; req_val = 1'b1; req_stage = 3'd1; req_lk = '0;
    step(); step();
    check_eq("rst_req_rdy", req_rdy, 0);
    check_eq("rst_stage_val", stage_val, 0);
    check_eq("rst_l_k", l_k, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cur_stage", cur_stage, 0);
    check_eq("rst_done_pulse", done_pulse, 0);
    check_eq("rst_done_stage", done_stage, 0);
    check_eq("rst_err", {err_val, err_code, err_flag}, 0);
    req_val = 1'b0;
    sys_rst = 1'b1;
    #1;
    check_eq("post_rst_req_rdy", req_rdy, 1);

    // PRD dispatch timing and completion
    send(3'd1, '0);
    check_eq("prd_k_stage_val", stage_val, 0);
    step();
    check_eq("prd_k1_stage_val", stage_val, 1);
    check_eq("prd_k1_l_k", l_k, 0);
    check_eq("prd_k1_busy", busy, 1);
    check_eq("prd_k1_cur", cur_stage, 1);
    step();
    check_eq("prd_k2_stage_val", stage_val, 1);
    step();
    check_eq("prd_k3_stage_val", stage_val, 0);
    repeat (247) step();
    check_eq("prd_wait_busy", busy, 1);
    check_eq("prd_wait_no_done", done_pulse, 0);
    stage_rdy = 3'd1;
    step();
    stage_rdy = '0;
    check_eq("prd_done_pulse", done_pulse, 1);
    check_eq("prd_done_stage", done_stage, 1);
    step();
    check_eq("prd_done_pulse_end", done_pulse, 0);
    check_eq("prd_busy_drop", busy, 0);
    check_eq("prd_cur_zero", cur_stage, 0);
    check_eq("prd_done_stage_held", done_stage, 1);

    // UPD straight after reset: ordering error
    do_reset();
    send(3'd3, '0);
    check_eq("order_k_stage_val", stage_val, 0);
    step();
    check_eq("order_err_val", err_val, 1);
    check_eq("order_err_code", err_code, 2);
    check_eq("order_err_flag", err_flag, 1);
    check_eq("order_stage_val", stage_val, 0);
    step();
    check_eq("order_err_val_end", err_val, 0);
    repeat (3) step();
    check_eq("order_stage_val_late", stage_val, 0);
    check_eq("order_busy_late", busy, 0);
    check_eq("order_flag_sticky", err_flag, 1);

    // landmark range rules after PRD
    do_reset();
    landmark_num = RL'(4);
    send(3'd1, RL'(7));
    serve(3'd1, RL'(7), 3);
    send(3'd2, RL'(4));
    check_eq("range_err_val", err_val, 1);
    check_eq("range_err_code", err_code, 1);
    step();
    check_eq("range_not_queued_sv", stage_val, 0);
    check_eq("range_not_queued_busy", busy, 0);
    send(3'd2, RL'(2));
    step();
    check_eq("new_stage_val", stage_val, 2);
    check_eq("new_l_k", l_k, 2);
    serve(3'd2, RL'(2), 5);

    // queue fill with the core stalled, then in-order completion
    do_reset();
    qs[0] = 3'd1; qs[1] = 3'd1; qs[2] = 3'd4; qs[3] = 3'd2; qs[4] = 3'd3; qs[5] = 3'd1;
    ql[0] = RL'(5); ql[1] = RL'(6); ql[2] = RL'(7); ql[3] = RL'(1); ql[4] = RL'(2); ql[5] = RL'(9);
    for (int i = 0; i < 6; i++) begin
      req_val = 1'b1; req_stage = qs[i]; req_lk = ql[i];
      #1;
      check_eq((i < 5) ? "fill_req_rdy" : "fill_full_req_rdy", req_rdy, (i < 5) ? 1 : 0);
      step();
    end
    req_val = 1'b0;
    for (int i = 0; i < 5; i++) serve(qs[i], ql[i], 2);
    repeat (4) step();
    check_eq("fill_sixth_dropped", cur_stage, 0);

    // timeout on the short-timeout instance
    do_reset();
    send(3'd1, RL'(1));
    send(3'd1, RL'(3));
    n = 0;
    while (t_stage_val != 3'd0 && n < 20) begin step(); n++; end
    seen_done = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (t_done_pulse) seen_done++;
    end
    check_eq("tmo_early_err", t_err_val, 0);
    check_eq("tmo_early_busy", t_busy, 1);
    step();
    if (t_done_pulse) seen_done++;
    check_eq("tmo_err_val", t_err_val, 1);
    check_eq("tmo_err_code", t_err_code, 3);
    check_eq("tmo_no_done", seen_done, 0);
    check_eq("tmo_idle", t_busy, 0);
    step();
    check_eq("tmo_next_stage", t_stage_val, 1);
    check_eq("tmo_next_lk", t_l_k, 3);

    // reset during WAIT with entries queued
    do_reset();
    landmark_num = RL'(4);
    send(3'd2, RL'(9));
    send(3'd1, RL'(1));
    send(3'd1, RL'(2));
    send(3'd1, RL'(3));
    n = 0;
    while ((stage_val != 3'd0 || !busy) && n < 20) begin step(); n++; end
    check_eq("mid_pre_flag", err_flag, 1);
    sys_rst = 1'b0;
    step();
    check_eq("mid_rst_req_rdy", req_rdy, 0);
    check_eq("mid_rst_outs", {stage_val, l_k, busy, cur_stage, done_pulse, done_stage}, 0);
    check_eq("mid_rst_err", {err_val, err_code, err_flag}, 0);
    sys_rst = 1'b1;
    repeat (4) step();
    check_eq("mid_queue_empty_sv", stage_val, 0);
    check_eq("mid_queue_empty_busy", busy, 0);
    send(3'd3, '0);
    step();
    check_eq("mid_order_err_val", err_val, 1);
    check_eq("mid_order_err_code", err_code, 2);

    random_phase();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ekf_stage_scheduler.md
# ekf_stage_scheduler

Queued stage sequencer that sits between the host and the EKF-SLAM `Top` core. It accepts stage requests (PRD / NEW / UPD / ASSOC plus landmark index) into a small FIFO and dispatches them one at a time. For each dispatch it drives the core's `stage_val` strobe for a fixed number of cycles, then waits for the matching `stage_rdy` completion code. It enforces stage-ordering and landmark-range rules and times out hung stages.

## Interface
- `QUEUE_DEPTH`, 4: request FIFO entries (power of 2).
- `ROW_LEN`, 10: landmark index width.
- `VAL_CYC`, 2: cycles `stage_val` is held per dispatch (≥1).
- `TIMEOUT_W`, 12: timeout counter width.
- `TIMEOUT`, 4095: WAIT cycles before a stage is declared hung (≤ 2^TIMEOUT_W−1).

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `sys_rst` in 1: synchronous, active-low reset.
- `req_val` in 1: host request valid.
- `req_stage` in 3: requested stage code (1 PRD, 2 NEW, 3 UPD, 4 ASSOC).
- `req_lk` in ROW_LEN: landmark index for the request.
- `req_rdy` out 1: FIFO can accept (combinational `!full`, forced 0 while `sys_rst` low).
- `landmark_num` in ROW_LEN: current landmark count (range check reference).
- `stage_val` out 3: stage strobe to core.
- `l_k` out ROW_LEN: landmark index to core, held for the whole dispatch.
- `stage_rdy` in 3: core completion code (stage code of the finished stage, 0 otherwise).
- `busy` out 1: FSM not in IDLE.
- `cur_stage` out 3: stage being executed (0 in IDLE).
- `done_pulse` out 1: one-cycle completion strobe.
- `done_stage` out 3: stage code that completed, held until next completion.
- `err_val` out 1: one-cycle error strobe.
- `err_code` out 2: 0 ILLEGAL_STAGE, 1 RANGE, 2 ORDER, 3 TIMEOUT. Valid with `err_val`, held otherwise.
- `err_flag` out 1: sticky OR of all errors, cleared only by reset.

## Operation
- Enqueue rules, checked at accept (`req_val & req_rdy`):
  - If `req_stage` ∉ {1..4}, raise ILLEGAL_STAGE and drop the request.
  - If `req_stage` is NEW or UPD and `req_lk >= landmark_num`, raise RANGE and drop.
  - Otherwise write {stage, lk} to the FIFO.
- The FSM has four states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If the FIFO is non-empty, pop the head.
  - If the head is NEW, UPD or ASSOC and `prd_done` = 0, raise ORDER, drop the entry and stay in IDLE.
  - Otherwise latch `cur_stage` and `l_k`, then go to ISSUE.
- ISSUE: `stage_val = cur_stage` for exactly `VAL_CYC` cycles, then go to WAIT. `stage_rdy` is ignored in ISSUE.
- WAIT:
  - On `stage_rdy == cur_stage`, go to DONE.
  - Non-matching nonzero `stage_rdy` is ignored.
  - The timeout counter increments every WAIT cycle. When it reaches `TIMEOUT`, raise TIMEOUT and go to IDLE with no done pulse.
- DONE:
  - `done_pulse = 1`, `done_stage = cur_stage`.
  - If the stage is PRD, set `prd_done`.
  - Go to IDLE; `cur_stage` returns to 0.
- `prd_done` is cleared only by reset.
- FIFO order is strict; dropped entries do not stall the queue.
- Error collisions: if an FSM error (ORDER/TIMEOUT) and an enqueue error fall in the same cycle, the FSM error is reported on `err_code`. `err_flag` is still set.
- FIFO boundaries:
  - Full: `req_rdy` = 0, even if a pop occurs that cycle.
  - Empty: no dispatch.
  - Pointers wrap modulo `QUEUE_DEPTH`.

## Timing
- Reset values:
  - Outputs `stage_val`, `l_k`, `busy`, `cur_stage`, `done_pulse`, `done_stage`, `err_val`, `err_code`, `err_flag` are all 0.
  - FIFO is empty, FSM is in IDLE, `prd_done` = 0.
- Reset asserted mid-operation: every state above reaches its reset value at the next edge. `stage_val` drops to 0 immediately after that edge, and queued entries are lost.
- Dispatch latency:
  - Request accepted at edge k (FSM idle, FIFO empty).
  - Pop at edge k+1.
  - `stage_val`/`l_k` are valid from edge k+1 for `VAL_CYC` cycles.
  - WAIT is entered at edge k+1+VAL_CYC.
- Completion: `stage_rdy` matching at edge m in WAIT gives `done_pulse` high for the cycle after m. IDLE follows, and the next pop can occur at edge m+2.
- All outputs except `req_rdy` are registered.
- `err_val` for enqueue errors is asserted the cycle after the accepting edge.

## Test plan
- Reset, then PRD request with `req_lk` = 0:
  - `stage_val` = 1 for exactly 2 cycles starting 1 cycle after accept.
  - `stage_rdy` = 1 after 250 cycles gives `done_pulse` one cycle later with `done_stage` = 1.
  - `busy` drops the following cycle.
- UPD request straight after reset: `err_val` with `err_code` = 2 (ORDER), `stage_val` never leaves 0, `err_flag` = 1 and stays 1.
- After PRD completes, with `landmark_num` = 4:
  - NEW with `req_lk` = 4 gives `err_code` = 1 (RANGE) and is not queued.
  - NEW with `req_lk` = 2 dispatches with `stage_val` = 2 and `l_k` = 2.
- Six back-to-back requests (PRD, PRD, ASSOC, NEW, UPD, PRD) with the core stalled and `QUEUE_DEPTH` = 4:
  - Five are accepted, then `req_rdy` = 0.
  - Stages issue in exactly that order as `stage_rdy` completions are returned.
- `TIMEOUT` = 16 and `stage_rdy` held 0: `err_code` = 3 (TIMEOUT) after the 16th WAIT cycle, no `done_pulse`, and the next queued entry dispatches.
- Reset pulsed (`sys_rst` = 0) during WAIT with 2 entries queued:
  - All outputs reach 0 at the next edge and the queue is empty.
  - A following UPD request gives ORDER, because `prd_done` was cleared.
